// File: rtl/muntjac_pkg.sv
// Shared core types: privilege, status, trap causes and interrupt bit layout.
// Also holds the interrupt priority order and the bit-to-cause mapping.
package muntjac_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;

  typedef struct packed {
    logic sie;
    logic mie;
  } status_t;

  typedef enum logic [4:0] {
    EXC_CAUSE_INSN_ADDR_MISA = 5'h00,
    EXC_CAUSE_IRQ_SOFTWARE_S = 5'h11,
    EXC_CAUSE_IRQ_SOFTWARE_M = 5'h13,
    EXC_CAUSE_IRQ_TIMER_S    = 5'h15,
    EXC_CAUSE_IRQ_TIMER_M    = 5'h17,
    EXC_CAUSE_IRQ_EXTERNAL_S = 5'h19,
    EXC_CAUSE_IRQ_EXTERNAL_M = 5'h1B
  } exc_cause_e;

  localparam int unsigned CSR_SSIX_BIT = 1;
  localparam int unsigned CSR_MSIX_BIT = 3;
  localparam int unsigned CSR_STIX_BIT = 5;
  localparam int unsigned CSR_MTIX_BIT = 7;
  localparam int unsigned CSR_SEIX_BIT = 9;
  localparam int unsigned CSR_MEIX_BIT = 11;

  localparam logic [11:0] IRQ_M_MASK = 12'h888;

  // Highest priority first: MEI, MSI, MTI, SEI, SSI, STI
  localparam logic [3:0] IRQ_PRIO [6] = '{
    4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5
  };

  function automatic exc_cause_e irq_cause(logic [3:0] idx);
    return exc_cause_e'({1'b1, idx});
  endfunction

endpackage

// File: rtl/muntjac_irq_sync.sv
// N-stage asynchronous-reset flop synchroniser for one interrupt line.
// Output is the last stage; all stages clear on reset.
module muntjac_irq_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= {q_q[Stages-2:0], d_i};
    end
  end

  assign q_o = q_q[Stages-1];

endmodule

// File: rtl/muntjac_irq_ctrl.sv
// Interrupt controller: builds mip, filters by enables/delegation/privilege
// and offers one prioritised cause to the pipeline via valid/ready.
module muntjac_irq_ctrl
  import muntjac_pkg::*;
#(
  parameter int unsigned SyncStages    = 2,
  parameter int unsigned HoldoffCycles = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       irq_software_m_i,
  input  logic       irq_timer_m_i,
  input  logic       irq_external_m_i,
  input  logic       irq_external_s_i,
  input  logic [2:0] mip_sw_i,
  input  logic [11:0] mie_i,
  input  logic [11:0] mideleg_i,
  input  status_t    status_i,
  input  priv_lvl_e  prv_i,
  output logic [11:0] mip_o,
  output logic       irq_valid_o,
  input  logic       irq_ready_i,
  output exc_cause_e irq_cause_o,
  output logic       irq_to_s_o,
  output logic       wake_o
);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    HOLDOFF
  } state_e;

  logic [3:0] async_d;
  logic [3:0] async_s;

  assign async_d = {irq_external_s_i, irq_external_m_i,
                    irq_timer_m_i, irq_software_m_i};

  for (genvar g = 0; g < 4; g++) begin : g_sync
    muntjac_irq_sync #(
      .Stages (SyncStages)
    ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (async_d[g]),
      .q_o    (async_s[g])
    );
  end

  logic [11:0] mip_d, mip_q;
  logic        wake_q;

  always_comb begin
    mip_d = '0;
    mip_d[CSR_MSIX_BIT] = async_s[0];
    mip_d[CSR_MTIX_BIT] = async_s[1];
    mip_d[CSR_MEIX_BIT] = async_s[2];
    mip_d[CSR_SEIX_BIT] = async_s[3] | mip_sw_i[2];
    mip_d[CSR_STIX_BIT] = mip_sw_i[1];
    mip_d[CSR_SSIX_BIT] = mip_sw_i[0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mip_q  <= '0;
      wake_q <= 1'b0;
    end else begin
      mip_q  <= mip_d;
      wake_q <= |(mip_q & mie_i);
    end
  end

  logic [11:0] deleg;
  logic [11:0] elig;
  logic        m_en, s_en, any;
  logic [3:0]  sel;

  assign deleg = mideleg_i & ~IRQ_M_MASK;
  assign m_en  = (prv_i != PRIV_LVL_M) || status_i.mie;
  assign s_en  = (prv_i == PRIV_LVL_U) ||
                 ((prv_i == PRIV_LVL_S) && status_i.sie);
  assign elig  = mip_q & mie_i &
                 ((~deleg & {12{m_en}}) | (deleg & {12{s_en}}));
  assign any   = |elig;

  // Walk lowest to highest so the highest-priority hit wins
  always_comb begin
    sel = '0;
    for (int i = 5; i >= 0; i--) begin
      if (elig[IRQ_PRIO[i]]) sel = IRQ_PRIO[i];
    end
  end

  state_e     state_q;
  logic       valid_q, to_s_q;
  exc_cause_e cause_q;
  logic [3:0] idx_q;
  logic [2:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      cause_q <= EXC_CAUSE_INSN_ADDR_MISA;
      to_s_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any) begin
            cause_q <= irq_cause(sel);
            to_s_q  <= deleg[sel];
            idx_q   <= sel;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (irq_ready_i) begin
            valid_q <= 1'b0;
            cnt_q   <= 3'(HoldoffCycles - 1);
            state_q <= HOLDOFF;
          end else if (!elig[idx_q]) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        HOLDOFF: begin
          if (cnt_q == '0) state_q <= IDLE;
          else cnt_q <= cnt_q - 3'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mip_o       = mip_q;
  assign wake_o      = wake_q;
  assign irq_valid_o = valid_q;
  assign irq_cause_o = cause_q;
  assign irq_to_s_o  = to_s_q;

endmodule

// File: tb/tb_muntjac_irq_ctrl.sv
// Directed bench for muntjac_irq_ctrl with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_muntjac_irq_ctrl;
  import muntjac_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       msi, mti, mei, sei;
  logic [2:0] mip_sw;
  logic [11:0] mie, mideleg;
  status_t    status;
  priv_lvl_e  prv;
  logic [11:0] mip;
  logic       valid, ready, to_s, wake;
  exc_cause_e cause;

  int total = 0;
  int bad   = 0;

  muntjac_irq_ctrl #(
    .SyncStages    (2),
    .HoldoffCycles (2)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .irq_software_m_i (msi),
    .irq_timer_m_i    (mti),
    .irq_external_m_i (mei),
    .irq_external_s_i (sei),
    .mip_sw_i         (mip_sw),
    .mie_i            (mie),
    .mideleg_i        (mideleg),
    .status_i         (status),
    .prv_i            (prv),
    .mip_o            (mip),
    .irq_valid_o      (valid),
    .irq_ready_i      (ready),
    .irq_cause_o      (cause),
    .irq_to_s_o       (to_s),
    .wake_o           (wake)
  );

  always #5 clk = ~clk;

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {msi, mti, mei, sei} = '0;
    mip_sw = '0;
    mie = '0;
    mideleg = '0;
    status = '0;
    prv = PRIV_LVL_M;
    ready = 1'b0;
    tick(2);
    chk("rst_valid", valid, 0);
    chk("rst_cause", cause, 0);
    chk("rst_to_s", to_s, 0);
    chk("rst_mip", mip, 0);
    chk("rst_wake", wake, 0);
    rst_n = 1'b1;
    tick();

    // Timer M from U-mode: 4-cycle latency
    prv = PRIV_LVL_U;
    mie = 12'h080;
    mti = 1'b1;
    tick(3);
    chk("mti_lat3", valid, 0);
    tick();
    chk("mti_lat4", valid, 1);
    chk("mti_cause", cause, EXC_CAUSE_IRQ_TIMER_M);
    chk("mti_to_s", to_s, 0);
    chk("mti_mip", mip, 12'h080);
    chk("mti_wake", wake, 1);
    ready = 1'b1;
    tick();
    chk("mti_acc", valid, 0);
    ready = 1'b0;
    mie = '0;
    mti = 1'b0;
    tick(6);
    chk("quiet1", valid, 0);

    // MEI and MSI together in M-mode: MEI wins, frozen, holdoff
    prv = PRIV_LVL_M;
    status.mie = 1'b1;
    mie = 12'hAAA;
    mei = 1'b1;
    msi = 1'b1;
    tick(4);
    chk("mei_valid", valid, 1);
    chk("mei_cause", cause, EXC_CAUSE_IRQ_EXTERNAL_M);
    tick(3);
    chk("mei_hold_v", valid, 1);
    chk("mei_hold_c", cause, EXC_CAUSE_IRQ_EXTERNAL_M);
    ready = 1'b1;
    tick();
    chk("hold0", valid, 0);
    ready = 1'b0;
    tick();
    chk("hold1", valid, 0);
    tick();
    chk("hold2", valid, 0);
    tick();
    chk("reoffer", valid, 1);
    chk("reoffer_c", cause, EXC_CAUSE_IRQ_EXTERNAL_M);
    mie = '0;
    tick();
    chk("mei_wdraw", valid, 0);
    mei = 1'b0;
    msi = 1'b0;
    status = '0;
    tick(4);

    // Delegated STI in S-mode
    mideleg = 12'h020;
    mip_sw = 3'b010;
    mie = 12'h020;
    prv = PRIV_LVL_S;
    status.sie = 1'b1;
    tick();
    chk("sti_lat1", valid, 0);
    tick();
    chk("sti_valid", valid, 1);
    chk("sti_cause", cause, EXC_CAUSE_IRQ_TIMER_S);
    chk("sti_to_s", to_s, 1);
    prv = PRIV_LVL_M;
    tick();
    chk("sti_m_wdraw", valid, 0);
    tick(2);
    chk("sti_m_none", valid, 0);
    chk("sti_m_wake", wake, 1);
    chk("sti_mip", mip, 12'h020);
    mip_sw = '0;
    mideleg = '0;
    mie = '0;
    status = '0;
    tick(3);

    // SSI withdrawal, then ready racing loss of eligibility
    prv = PRIV_LVL_U;
    mie = 12'h002;
    mip_sw = 3'b001;
    tick(2);
    chk("ssi_valid", valid, 1);
    chk("ssi_cause", cause, EXC_CAUSE_IRQ_SOFTWARE_S);
    mip_sw = 3'b000;
    tick();
    chk("ssi_still", valid, 1);
    tick();
    chk("ssi_wdraw", valid, 0);
    tick();
    chk("ssi_idle", valid, 0);
    mip_sw = 3'b001;
    tick(2);
    chk("ssi_valid2", valid, 1);
    mip_sw = 3'b000;
    tick();
    ready = 1'b1;
    tick();
    chk("race_acc", valid, 0);
    ready = 1'b0;
    mip_sw = 3'b001;
    tick(2);
    chk("race_hold", valid, 0);
    tick();
    chk("race_back", valid, 1);
    mip_sw = '0;
    mie = '0;
    tick(3);

    // MSI masked by status.mie in M-mode
    prv = PRIV_LVL_M;
    status = '0;
    mie = 12'h008;
    msi = 1'b1;
    tick(5);
    chk("msi_masked", valid, 0);
    chk("msi_wake", wake, 1);
    status.mie = 1'b1;
    tick();
    chk("msi_valid", valid, 1);
    chk("msi_cause", cause, EXC_CAUSE_IRQ_SOFTWARE_M);

    // Async reset mid-offer
    rst_n = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_mip", mip, 0);
    chk("arst_wake", wake, 0);
    tick();
    rst_n = 1'b1;
    tick(3);
    chk("arst_lat3", valid, 0);
    tick();
    chk("arst_lat4", valid, 1);
    chk("arst_cause", cause, EXC_CAUSE_IRQ_SOFTWARE_M);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
